// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Purpose  : In-order instruction buffer with a dual-issue selector feeding
//            pipe 0 (main: LSU/CSR/branch) and pipe 1 (sub: MDU). Accepts up
//            to two decoded instructions per cycle and issues 0..2 head entries
//            per cycle. Honours pipe-class limits, intra-pair RAW/WAW
//            dependencies and load-use hazards. Empties on flush.
// Options  : ISSUE_DUAL_EN - when defined, the second head entry may issue
//            alongside the first; when undefined, one issue per cycle.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid_i/in_ready_o, in_payload_i, in_pc_i, in_wreg_i,
//            in_rreg_i, in_class_i, in_is_load_i  - decoder side (2 slots)
//            stall_i, flush_i                     - backend control
//            issue_o, out_payload_o, out_pc_o     - per-pipe issue outputs
//            count_o                              - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                in_valid_i,
  output logic                      in_ready_o,
  input  logic [1:0][PAYLOAD_W-1:0] in_payload_i,
  input  logic [1:0][31:0]          in_pc_i,
  input  logic [1:0][4:0]           in_wreg_i,
  input  logic [1:0][1:0][4:0]      in_rreg_i,
  input  logic [1:0][1:0]           in_class_i,
  input  logic [1:0]                in_is_load_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [1:0]                issue_o,
  output logic [1:0][PAYLOAD_W-1:0] out_payload_o,
  output logic [1:0][31:0]          out_pc_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [1:0]    CLS_MAIN  = 2'd1;
  localparam logic [1:0]    CLS_SUB   = 2'd2;
  localparam logic [CW-1:0] SLACK_LIM = CW'(DEPTH - 2);

  // Entry storage
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
  logic [31:0]          pc_q   [DEPTH];
  logic [4:0]           wreg_q [DEPTH];
  logic [1:0][4:0]      rreg_q [DEPTH];
  logic [1:0]           cls_q  [DEPTH];
  logic [DEPTH-1:0]     ld_q;

  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  // Load tracker: loads currently in EX and M1
  logic          ldex_v_q, ldm1_v_q;
  logic [4:0]    ldex_r_q, ldm1_r_q;

  logic [1:0]    enq_n, deq_n;
  logic [AW-1:0] wr1_idx, h0, p0_idx, p1_idx;
  logic          h0_lu, h0_go, h0_main, h0_sub, h0_p1, h1_go;
  logic          ld_v;
  logic [4:0]    ld_r;

  function automatic logic load_use(input logic [1:0][4:0] src,
                                    input logic v0, input logic [4:0] r0,
                                    input logic v1, input logic [4:0] r1);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (src[s] != 5'd0 && ((v0 && src[s] == r0) || (v1 && src[s] == r1)))
        hit = 1'b1;
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------- enqueue
  assign in_ready_o = rst_n & ~flush_i & (count_q <= SLACK_LIM);
  assign enq_n      = in_ready_o ? ({1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]}) : 2'd0;
  // Slot 1 lands right after slot 0 (or at tail if slot 0 is empty)
  assign wr1_idx    = tail_q + AW'(in_valid_i[0]);
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (in_ready_o && in_valid_i[0]) begin
      pay_q[tail_q]  <= in_payload_i[0];
      pc_q[tail_q]   <= in_pc_i[0];
      wreg_q[tail_q] <= in_wreg_i[0];
      rreg_q[tail_q] <= in_rreg_i[0];
      cls_q[tail_q]  <= in_class_i[0];
      ld_q[tail_q]   <= in_is_load_i[0];
    end
    if (in_ready_o && in_valid_i[1]) begin
      pay_q[wr1_idx]  <= in_payload_i[1];
      pc_q[wr1_idx]   <= in_pc_i[1];
      wreg_q[wr1_idx] <= in_wreg_i[1];
      rreg_q[wr1_idx] <= in_rreg_i[1];
      cls_q[wr1_idx]  <= in_class_i[1];
      ld_q[wr1_idx]   <= in_is_load_i[1];
    end
  end

  // ---------------------------------------------------------- issue select
  assign h0 = head_q;

`ifdef ISSUE_DUAL_EN
  logic [AW-1:0] h1;
  logic          h1_lu, h1_main, h1_sub, h1_ok, h1_fit, raw, waw;
  assign h1 = head_q + AW'(1);
`endif

  always_comb begin
    h0_lu   = load_use(rreg_q[h0], ldex_v_q, ldex_r_q, ldm1_v_q, ldm1_r_q);
    h0_go   = rst_n & ~stall_i & ~flush_i & (count_q != '0) & ~h0_lu;
    h0_main = (cls_q[h0] == CLS_MAIN);
    h0_sub  = (cls_q[h0] == CLS_SUB);
`ifdef ISSUE_DUAL_EN
    h1_lu   = load_use(rreg_q[h1], ldex_v_q, ldex_r_q, ldm1_v_q, ldm1_r_q);
    h1_main = (cls_q[h1] == CLS_MAIN);
    h1_sub  = (cls_q[h1] == CLS_SUB);
    raw     = (rreg_q[h1][0] != 5'd0 && rreg_q[h1][0] == wreg_q[h0]) ||
              (rreg_q[h1][1] != 5'd0 && rreg_q[h1][1] == wreg_q[h0]);
    waw     = (wreg_q[h1] != 5'd0) && (wreg_q[h1] == wreg_q[h0]);
    // Pairing legality independent of which pipe each entry takes
    h1_ok   = (count_q >= CW'(2)) & h0_go & ~raw & ~waw & ~h1_lu;
    // An ALU head yields pipe 0 to a MAIN-only partner that can pair with it
    h0_p1   = h0_sub | (~h0_main & ~h0_sub & h1_main & h1_ok);
    h1_fit  = h0_p1 ? ~h1_sub : ~h1_main;
    // A MAIN head (branch-class) only pairs with a SUB-only partner
    h1_go   = h1_ok & h1_fit & ~(h0_main & ~h1_sub);
    p0_idx  = h0_p1 ? h1 : h0;
    p1_idx  = h0_p1 ? h0 : h1;
    ld_v    = (h0_go & ld_q[h0]) | (h1_go & ld_q[h1]);
    ld_r    = (h0_go & ld_q[h0]) ? wreg_q[h0] : wreg_q[h1];
`else
    h0_p1   = h0_sub;
    h1_go   = 1'b0;
    p0_idx  = h0;
    p1_idx  = h0;
    ld_v    = h0_go & ld_q[h0];
    ld_r    = wreg_q[h0];
`endif
    issue_o[0] = (h0_go & ~h0_p1) | (h1_go & h0_p1);
    issue_o[1] = (h0_go & h0_p1)  | (h1_go & ~h0_p1);
    deq_n      = {1'b0, h0_go} + {1'b0, h1_go};

    out_pc_o      = '0;
    out_payload_o = '0;
    if (issue_o[0]) begin
      out_pc_o[0]      = pc_q[p0_idx];
      out_payload_o[0] = pay_q[p0_idx];
    end
    if (issue_o[1]) begin
      out_pc_o[1]      = pc_q[p1_idx];
      out_payload_o[1] = pay_q[p1_idx];
    end
  end

  // ------------------------------------------------ pointers and tracker
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ldex_v_q <= 1'b0;
      ldex_r_q <= '0;
      ldm1_v_q <= 1'b0;
      ldm1_r_q <= '0;
    end else begin
      head_q  <= head_q + AW'(deq_n);
      tail_q  <= tail_q + AW'(enq_n);
      count_q <= count_q + CW'(enq_n) - CW'(deq_n);
      if (!stall_i) begin
        ldex_v_q <= ld_v;
        ldex_r_q <= ld_r;
        ldm1_v_q <= ldex_v_q;
        ldm1_r_q <= ldex_r_q;
      end
    end
  end

endmodule
`default_nettype wire
